// File: rtl/decode_stage.sv
// Decode and operand-issue stage: register file with writeback bypass, dependency
// slots for the two instructions ahead, stall/flush handling and a sticky HALT state.
module decode_stage #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           instr,
   input  logic                  instr_valid,
   output logic                  stall,
   input  logic                  flush,
   input  logic                  wb_we,
   input  logic [3:0]            wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  is_add,
   output logic                  is_sub,
   output logic                  is_and,
   output logic                  is_or,
   output logic                  is_gt,
   output logic                  is_eq,
   output logic                  is_reg_write,
   output logic                  is_branch,
   output logic                  is_halt,
   output logic                  is_mem_write,
   output logic [DATA_WIDTH-1:0] val1,
   output logic [DATA_WIDTH-1:0] val2,
   output logic [DATA_WIDTH-1:0] val3,
   output logic                  is_val1_data_hazard,
   output logic                  is_val2_data_hazard,
   output logic                  is_mem_data_hazard
);

   localparam int unsigned REG_ADDR_WIDTH = 4;
   localparam int unsigned REG_COUNT      = 16;

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_GT   = 4'h5;
   localparam logic [3:0] OP_EQ   = 4'h6;
   localparam logic [3:0] OP_LI   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BGT  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   typedef struct packed {
      logic                  add;
      logic                  sub;
      logic                  and_op;
      logic                  or_op;
      logic                  gt;
      logic                  eq;
      logic                  reg_write;
      logic                  branch;
      logic                  halt;
      logic [DATA_WIDTH-1:0] v1;
      logic [DATA_WIDTH-1:0] v2;
      logic [DATA_WIDTH-1:0] v3;
      logic                  h1;
      logic                  h2;
      logic                  hm;
   } issue_t;

   // Register read with write-through from the writeback port; R0 is hardwired to zero.
   function automatic logic [DATA_WIDTH-1:0] bypass_read(
      input logic [REG_ADDR_WIDTH-1:0] idx,
      input logic [DATA_WIDTH-1:0]     stored,
      input logic                      we,
      input logic [REG_ADDR_WIDTH-1:0] wa,
      input logic [DATA_WIDTH-1:0]     wd
   );
      logic [DATA_WIDTH-1:0] r;
      r = stored;
      if (idx == '0) begin
         r = '0;
      end else if (we && (wa == idx)) begin
         r = wd;
      end
      return r;
   endfunction

   logic [DATA_WIDTH-1:0]     regs [REG_COUNT];
   logic [3:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] rd, rs1, rs2;
   logic [DATA_WIDTH-1:0]     rdata1, rdata2, rdata3;

   state_t                    state;
   logic                      e_valid, m_valid;
   logic [REG_ADDR_WIDTH-1:0] e_dest, m_dest;
   issue_t                    out_q, nxt;

   logic op_alu, op_li, op_branch, op_halt, uses_src;
   logic e_hit1, e_hit2, m_hit1, m_hit2;
   logic mem_fwd, src_stall, tgt_stall, hazard_stall, issue;

   assign opcode = instr[15:12];
   assign rd     = instr[11:8];
   assign rs1    = instr[7:4];
   assign rs2    = instr[3:0];

   assign rdata1 = bypass_read(rs1, regs[rs1], wb_we, wb_addr, wb_data);
   assign rdata2 = bypass_read(rs2, regs[rs2], wb_we, wb_addr, wb_data);
   assign rdata3 = bypass_read(rd,  regs[rd],  wb_we, wb_addr, wb_data);

   // Register file; R0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_we && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Opcode class decode; unlisted opcodes fall through as NOP.
   always_comb begin
      op_alu    = 1'b0;
      op_li     = 1'b0;
      op_branch = 1'b0;
      op_halt   = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_GT, OP_EQ: op_alu    = 1'b1;
         OP_LI:                                       op_li     = 1'b1;
         OP_BEQ, OP_BGT:                              op_branch = 1'b1;
         OP_HALT:                                     op_halt   = 1'b1;
         default:                                     op_alu    = 1'b0;
      endcase
   end

   assign uses_src = op_alu || op_branch;

   // Source matching: the youngest producer (E) wins over the older one (M).
   always_comb begin
      e_hit1    = e_valid && (rs1 != '0) && (rs1 == e_dest);
      e_hit2    = e_valid && (rs2 != '0) && (rs2 == e_dest);
      m_hit1    = m_valid && (rs1 != '0) && (rs1 == m_dest) && !e_hit1;
      m_hit2    = m_valid && (rs2 != '0) && (rs2 == m_dest) && !e_hit2;
      mem_fwd   = uses_src && m_hit1 && m_hit2 && (rs1 == rs2);
      src_stall = uses_src && (m_hit1 || m_hit2) && !mem_fwd;
      tgt_stall = op_branch && (rd != '0) &&
                  ((e_valid && (rd == e_dest)) || (m_valid && (rd == m_dest)));
      hazard_stall = src_stall || tgt_stall;
   end

   // Flush overrides everything, including the HALTED hold.
   always_comb begin
      stall = 1'b0;
      if (!flush && instr_valid) begin
         stall = (state == ST_HALTED) ? 1'b1 : hazard_stall;
      end
   end

   assign issue = !flush && instr_valid && (state == ST_RUN) && !hazard_stall;

   // Next issue-register contents; anything not issued is a bubble.
   always_comb begin
      nxt = '0;
      if (issue) begin
         case (opcode)
            OP_ADD:  nxt.add    = 1'b1;
            OP_SUB:  nxt.sub    = 1'b1;
            OP_AND:  nxt.and_op = 1'b1;
            OP_OR:   nxt.or_op  = 1'b1;
            OP_GT:   nxt.gt     = 1'b1;
            OP_EQ:   nxt.eq     = 1'b1;
            OP_LI:   nxt.add    = 1'b1;
            OP_BEQ:  nxt.eq     = 1'b1;
            OP_BGT:  nxt.gt     = 1'b1;
            OP_HALT: nxt.halt   = 1'b1;
            default: nxt.add    = 1'b0;
         endcase
         if (uses_src) begin
            nxt.v1 = rdata1;
            nxt.v2 = rdata2;
            nxt.h1 = e_hit1 || mem_fwd;
            nxt.h2 = e_hit2 || mem_fwd;
            nxt.hm = mem_fwd;
         end
         if (op_alu) begin
            nxt.v3        = DATA_WIDTH'(rd);
            nxt.reg_write = (rd != '0);
         end
         if (op_li) begin
            nxt.v1        = DATA_WIDTH'(instr[7:0]);
            nxt.v3        = DATA_WIDTH'(rd);
            nxt.reg_write = (rd != '0);
         end
         if (op_branch) begin
            nxt.v3     = rdata3;
            nxt.branch = 1'b1;
         end
      end
   end

   // Control state, dependency slots and the registered execute boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_RUN;
         e_valid <= 1'b0;
         e_dest  <= '0;
         m_valid <= 1'b0;
         m_dest  <= '0;
         out_q   <= '0;
      end else begin
         out_q <= nxt;
         if (flush) begin
            e_valid <= 1'b0;
            m_valid <= 1'b0;
         end else begin
            m_valid <= e_valid;
            m_dest  <= e_dest;
            e_valid <= issue && nxt.reg_write;
            e_dest  <= rd;
         end
         if (issue && op_halt) begin
            state <= ST_HALTED;
         end
      end
   end

   assign is_add              = out_q.add;
   assign is_sub              = out_q.sub;
   assign is_and              = out_q.and_op;
   assign is_or               = out_q.or_op;
   assign is_gt               = out_q.gt;
   assign is_eq               = out_q.eq;
   assign is_reg_write        = out_q.reg_write;
   assign is_branch           = out_q.branch;
   assign is_halt             = out_q.halt;
   assign is_mem_write        = 1'b0;
   assign val1                = out_q.v1;
   assign val2                = out_q.v2;
   assign val3                = out_q.v3;
   assign is_val1_data_hazard = out_q.h1;
   assign is_val2_data_hazard = out_q.h2;
   assign is_mem_data_hazard  = out_q.hm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: cycle-by-cycle vector table plus halt/reset sequences.
module tb_decode_stage;

   typedef struct packed {
      logic        add, sub, and_op, or_op, gt, eq;
      logic        rw, br, halt, memw;
      logic        h1, h2, hm;
      logic [15:0] v1, v2, v3;
   } out_t;

   typedef struct {
      string       name;
      logic [15:0] instr;
      logic        valid;
      logic        flush;
      logic        we;
      logic [3:0]  wa;
      logic [15:0] wd;
      logic        exp_stall;
      out_t        exp;
   } vec_t;

   localparam logic [5:0] S_ADD = 6'b100000;
   localparam logic [5:0] S_SUB = 6'b010000;
   localparam logic [5:0] S_AND = 6'b001000;
   localparam logic [5:0] S_OR  = 6'b000100;
   localparam logic [5:0] S_GT  = 6'b000010;
   localparam logic [5:0] S_EQ  = 6'b000001;

   logic        clk, rst;
   logic [15:0] instr;
   logic        instr_valid, stall, flush;
   logic        wb_we;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        is_add, is_sub, is_and, is_or, is_gt, is_eq;
   logic        is_reg_write, is_branch, is_halt, is_mem_write;
   logic [15:0] val1, val2, val3;
   logic        is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard;
   out_t        act;
   vec_t        vecs[$];
   int          errors = 0;
   int          checks = 0;

   decode_stage #(.DATA_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .stall(stall),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .is_add(is_add), .is_sub(is_sub), .is_and(is_and), .is_or(is_or),
      .is_gt(is_gt), .is_eq(is_eq), .is_reg_write(is_reg_write), .is_branch(is_branch),
      .is_halt(is_halt), .is_mem_write(is_mem_write), .val1(val1), .val2(val2), .val3(val3),
      .is_val1_data_hazard(is_val1_data_hazard), .is_val2_data_hazard(is_val2_data_hazard),
      .is_mem_data_hazard(is_mem_data_hazard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign act = {is_add, is_sub, is_and, is_or, is_gt, is_eq, is_reg_write, is_branch,
                 is_halt, is_mem_write, is_val1_data_hazard, is_val2_data_hazard,
                 is_mem_data_hazard, val1, val2, val3};

   function automatic out_t mk(input logic [5:0] sel, input logic rw, input logic br,
                               input logic hl, input logic [2:0] hz,
                               input logic [15:0] v1, input logic [15:0] v2,
                               input logic [15:0] v3);
      out_t o;
      o = '0;
      {o.add, o.sub, o.and_op, o.or_op, o.gt, o.eq} = sel;
      o.rw   = rw;
      o.br   = br;
      o.halt = hl;
      {o.h1, o.h2, o.hm} = hz;
      o.v1 = v1;
      o.v2 = v2;
      o.v3 = v3;
      return o;
   endfunction

   function automatic out_t bub();
      return mk(6'b0, 1'b0, 1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 16'h0);
   endfunction

   task automatic add_vec(input string n, input logic [15:0] i, input logic v,
                          input logic f, input logic we, input logic [3:0] wa,
                          input logic [15:0] wd, input logic st, input out_t e);
      vec_t t;
      t.name = n; t.instr = i; t.valid = v; t.flush = f;
      t.we = we; t.wa = wa; t.wd = wd; t.exp_stall = st; t.exp = e;
      vecs.push_back(t);
   endtask

   task automatic apply(input logic [15:0] i, input logic v, input logic f,
                        input logic we, input logic [3:0] wa, input logic [15:0] wd);
      instr = i; instr_valid = v; flush = f;
      wb_we = we; wb_addr = wa; wb_data = wd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_out(input string n, input out_t e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: outputs got %h expected %h", n, act, e);
      end
   endtask

   task automatic check_stall(input string n, input logic e);
      checks++;
      if (stall !== e) begin
         errors++;
         $display("FAIL %s: stall got %b expected %b", n, stall, e);
      end
   endtask

   initial begin
      // Each row is one cycle: inputs, expected comb stall, expected issue after the edge.
      add_vec("pre_r1",        16'h0000, 0, 0, 1, 4'd1, 16'h0005, 0, bub());
      add_vec("pre_r2",        16'h0000, 0, 0, 1, 4'd2, 16'h0007, 0, bub());
      add_vec("add_basic",     16'h1312, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h5, 16'h7, 16'h3));
      add_vec("sub_e_fwd",     16'h2431, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_SUB, 1, 0, 0, 3'b100, 16'h0, 16'h5, 16'h4));
      add_vec("add_r5",        16'h1512, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h5, 16'h7, 16'h5));
      add_vec("nop",           16'h0000, 1, 0, 0, 4'd0, 16'h0, 0, bub());
      add_vec("and_mem_fwd",   16'h3655, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_AND, 1, 0, 0, 3'b111, 16'h0, 16'h0, 16'h6));
      add_vec("add_r5_b",      16'h1512, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h5, 16'h7, 16'h5));
      add_vec("nop_b",         16'h0000, 1, 0, 0, 4'd0, 16'h0, 0, bub());
      add_vec("or_m_stall",    16'h4651, 1, 0, 0, 4'd0, 16'h0, 1, bub());
      add_vec("or_bypass",     16'h4651, 1, 0, 1, 4'd5, 16'h000C, 0, mk(S_OR, 1, 0, 0, 3'b000, 16'hC, 16'h5, 16'h6));
      add_vec("li_r7",         16'h7740, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h40, 16'h0, 16'h7));
      add_vec("beq_stall_e",   16'h8712, 1, 0, 0, 4'd0, 16'h0, 1, bub());
      add_vec("beq_stall_m",   16'h8712, 1, 0, 0, 4'd0, 16'h0, 1, bub());
      add_vec("beq_issue",     16'h8712, 1, 0, 1, 4'd7, 16'h0040, 0, mk(S_EQ, 0, 1, 0, 3'b000, 16'h5, 16'h7, 16'h40));
      add_vec("add_r9",        16'h1911, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h5, 16'h5, 16'h9));
      add_vec("flush_add",     16'h1211, 1, 1, 0, 4'd0, 16'h0, 0, bub());
      add_vec("after_flush",   16'h2829, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_SUB, 1, 0, 0, 3'b000, 16'h7, 16'h0, 16'h8));
      add_vec("flush_halt",    16'hF000, 1, 1, 0, 4'd0, 16'h0, 0, bub());
      add_vec("run_after_fh",  16'h1312, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h5, 16'h7, 16'h3));
      add_vec("unknown_op",    16'hA123, 1, 0, 0, 4'd0, 16'h0, 0, bub());
      add_vec("add_r0_dest",   16'h1012, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 0, 0, 0, 3'b000, 16'h5, 16'h7, 16'h0));
      add_vec("r0_src_wr0",    16'h1400, 1, 0, 1, 4'd0, 16'hFFFF, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h0, 16'h0, 16'h4));
      add_vec("gt_e_fwd",      16'h5141, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_GT, 1, 0, 0, 3'b100, 16'h0, 16'h5, 16'h1));
      add_vec("mix_e_m_stall", 16'h6814, 1, 0, 0, 4'd0, 16'h0, 1, bub());
      add_vec("mix_m_stall",   16'h6814, 1, 0, 0, 4'd0, 16'h0, 1, bub());
      add_vec("mix_issue",     16'h6814, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_EQ, 1, 0, 0, 3'b000, 16'h5, 16'h0, 16'h8));
      add_vec("bgt_e_fwd",     16'h9281, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_GT, 0, 1, 0, 3'b100, 16'h0, 16'h5, 16'h7));
      add_vec("idle",          16'h1312, 0, 0, 0, 4'd0, 16'h0, 0, bub());
      add_vec("add_r10",       16'h1A12, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_ADD, 1, 0, 0, 3'b000, 16'h5, 16'h7, 16'hA));
      add_vec("idle_shift",    16'h0000, 0, 0, 0, 4'd0, 16'h0, 0, bub());
      add_vec("idle_m_stall",  16'h4BA1, 1, 0, 0, 4'd0, 16'h0, 1, bub());
      add_vec("idle_m_issue",  16'h4BA1, 1, 0, 0, 4'd0, 16'h0, 0, mk(S_OR, 1, 0, 0, 3'b000, 16'h0, 16'h5, 16'hB));

      rst = 1'b0;
      apply(16'h1312, 1, 0, 0, 4'd0, 16'h0);
      tick();
      tick();
      check_out("reset_outputs", bub());
      check_stall("reset_stall", 1'b0);
      rst = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         apply(vecs[k].instr, vecs[k].valid, vecs[k].flush, vecs[k].we, vecs[k].wa, vecs[k].wd);
         check_stall(vecs[k].name, vecs[k].exp_stall);
         tick();
         check_out(vecs[k].name, vecs[k].exp);
      end

      // HALT, then held bubbles with stall while instructions keep arriving.
      apply(16'hF000, 1, 0, 0, 4'd0, 16'h0);
      check_stall("halt_stall", 1'b0);
      tick();
      check_out("halt_issue", mk(6'b0, 0, 0, 1, 3'b000, 16'h0, 16'h0, 16'h0));
      apply(16'h1312, 1, 0, 0, 4'd0, 16'h0);
      check_stall("halted_stall_1", 1'b1);
      tick();
      check_out("halted_bubble_1", bub());
      check_stall("halted_stall_2", 1'b1);
      tick();
      check_out("halted_bubble_2", bub());

      // Asynchronous reset while halted and stalling.
      #2 rst = 1'b0;
      #1;
      check_out("rst_halted_outputs", bub());
      check_stall("rst_halted_stall", 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_stall("post_rst_stall", 1'b0);
      tick();
      check_out("post_rst_add", mk(S_ADD, 1, 0, 0, 3'b000, 16'h0, 16'h0, 16'h3));

      // Asynchronous reset with a live instruction on the outputs.
      #2 rst = 1'b0;
      #1;
      check_out("rst_mid_outputs", bub());
      @(negedge clk);
      rst = 1'b1;
      apply(16'h2433, 1, 0, 0, 4'd0, 16'h0);
      check_stall("post_rst2_stall", 1'b0);
      tick();
      check_out("post_rst2_sub", mk(S_SUB, 1, 0, 0, 3'b000, 16'h0, 16'h0, 16'h4));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
